reg_dump_reader: RTL and testbench
==================================

# reg_dump_reader

Sequential reader that walks a contiguous, wrap-capable range of architectural registers through one read port of the register file. It streams each `{index, value}` pair out on a valid/ready interface. It sits beside the ID-stage register file and feeds the debug/trace path, for example a register dump on halt or the test harness end-of-run check. It never writes the register file.

## Interface
Parameters:
- `NUM_REGS`, 32, number of architectural registers.
- `ADDR_W`, 5, register index width.
- `DATA_W`, 32, register data width.

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: request a dump. Sampled only in IDLE.
- `first_reg` in ADDR_W: first index to read. Sampled with `start`.
- `last_reg` in ADDR_W: last index to read. Sampled with `start`.
- `busy` out 1: high whenever state is not IDLE.
- `done` out 1: one-cycle pulse after the final beat is accepted.
- `rf_addr` out ADDR_W: register file read address.
- `rf_data` in DATA_W: combinational read data for `rf_addr`.
- `out_valid` out 1: output beat valid.
- `out_ready` in 1: sink accepts the beat.
- `out_index` out ADDR_W: register index of the beat.
- `out_data` out DATA_W: register value of the beat.
- `out_last` out 1: marks the final beat of the dump.

## Operation
- States are IDLE, RUN and DRAIN.
  - IDLE, `start`=1: `idx<=first_reg`, `last<=last_reg`, go to RUN.
  - RUN: the output slot is free when `!out_valid || out_ready`. When free, capture `rf_data`, `idx` and `idx==last` into the output registers and set `out_valid<=1`.
    - If `idx==last`, go to DRAIN.
    - Otherwise `idx<=idx+1` mod NUM_REGS. The index wraps from 31 to 0.
  - DRAIN: on `out_valid && out_ready`, clear `out_valid`, pulse `done`, go to IDLE.
- Beat count is `((last_reg - first_reg) mod NUM_REGS) + 1`.
  - `first==last` gives 1 beat.
  - `first=last+1` (mod 32) gives 32 beats.
- `rf_addr` equals `idx` in RUN and is 0 in IDLE/DRAIN.
- x0 is read through the file like any other register; its value is whatever the file returns (0).
- The dump is not an atomic snapshot. Each beat carries the value present in its capture cycle, so a concurrent write-back before capture is visible.
- `start` while `busy` is ignored. `first_reg`/`last_reg` are ignored outside the start cycle.
- Backpressure rules:
  - While `out_valid && !out_ready`: `out_index`, `out_data` and `out_last` are held stable, and `idx` does not advance.
  - `out_valid` never drops without a handshake except on reset.
- Reset, including mid-dump: state is IDLE, and all outputs are 0 (`busy`, `done`, `rf_addr`, `out_valid`, `out_index`, `out_data`, `out_last`). An in-flight beat is discarded and no `done` pulse is generated.

## Timing
- All outputs are registered or decoded from registered state. There is no combinational path from `out_ready` or `start` to any output.
- `start` accepted in cycle N:
  - `busy=1` and `rf_addr=first_reg` from cycle N+1.
  - First `out_valid` in cycle N+2.
- With `out_ready` held high, throughput is one beat per cycle, back-to-back.
- The final handshake in cycle M gives `done=1` in cycle M+1 only, with `busy=0` from M+1. A new `start` is accepted in M+1.
- Each stall cycle (`out_ready=0` with `out_valid=1`) delays every later beat and `done` by exactly one cycle.

## Structure
- `XLEN`, `REG_ADDR_W`, `NUM_REGS` and the state encodings (IDLE=0, RUN=1, DRAIN=2) belong in the shared CPU defines package, also used by the register file.
- The block is a single module with no sub-modules. The output slot is a one-entry pipeline register inside the module.

## Test plan
- **Reset:** assert `reset` with random inputs → all outputs 0 during reset and in the first cycle after release.
- **Full dump:** preload x_i=0x1000+i, `first=0`, `last=31`, `out_ready=1` → 32 consecutive beats.
  - `out_index` runs 0..31, `out_data[0]=0`, `out_data[5]=0x1005`.
  - `out_last` is set only on index 31.
  - `done` pulses one cycle after that beat.
- **Backpressure:** same dump with `out_ready` pattern 1,0,0,1,0,1… → exactly 32 beats in order with no loss or duplication. Data is stable while stalled, and `rf_addr` does not advance.
- **Wrap:** `first=30`, `last=1` → 4 beats with indices 30,31,0,1. `out_last` is set on index 1.
- **Single/ignored start:** `first=last=7` → one beat, `out_index=7`, `out_last=1`. A second `start` pulsed while `busy` is ignored, with no extra beats.
- **Reset mid-dump:** reset after 3 accepted beats of a 0..31 dump → outputs 0 and no `done`. A new `first=2`, `last=3` dump afterwards yields indices 2,3 correctly.

Source files
------------

// File: rtl/reg_dump_reader_pkg.sv
// rtl/reg_dump_reader_pkg.sv - shared CPU defines: register file geometry and dump reader state encoding
package reg_dump_reader_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  // Dump reader sequencing; encodings are fixed so trace tooling can decode them.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } dump_state_e;

endpackage

// File: rtl/reg_dump_reader_if.sv
// rtl/reg_dump_reader_if.sv - control, register-file read port and output stream of the dump reader
interface reg_dump_reader_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);

  // Control
  logic              start;
  logic [ADDR_W-1:0] first_reg;
  logic [ADDR_W-1:0] last_reg;
  logic              busy;
  logic              done;

  // Register file read port
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_data;

  // Output stream of {index, value} beats
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_index;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  // Reader side
  modport master (
    input  start, first_reg, last_reg, rf_data, out_ready,
    output busy, done, rf_addr, out_valid, out_index, out_data, out_last
  );

  // Requester / register file / sink side
  modport slave (
    output start, first_reg, last_reg, rf_data, out_ready,
    input  busy, done, rf_addr, out_valid, out_index, out_data, out_last
  );

endinterface

// File: rtl/reg_dump_reader.sv
// rtl/reg_dump_reader.sv - walks a wrap-capable register range and streams {index, value} beats
module reg_dump_reader #(
  parameter int NUM_REGS = reg_dump_reader_pkg::NUM_REGS,
  parameter int ADDR_W   = reg_dump_reader_pkg::REG_ADDR_W,
  parameter int DATA_W   = reg_dump_reader_pkg::XLEN
) (
  input logic               clk,
  input logic               reset,
  reg_dump_reader_if.master dump
);

  import reg_dump_reader_pkg::*;

  dump_state_e       state_q;
  logic [ADDR_W-1:0] idx_q;
  logic [ADDR_W-1:0] idx_d;
  logic [ADDR_W-1:0] last_q;
  logic              out_valid_q;
  logic [ADDR_W-1:0] out_index_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_last_q;
  logic              done_q;
  logic              slot_free;
  logic              at_last;

  // Successor index, wrapping from the top register back to x0.
  assign idx_d     = (idx_q == ADDR_W'(NUM_REGS - 1)) ? '0 : idx_q + ADDR_W'(1);
  // The one-entry output slot can take a beat when empty or being drained this cycle.
  assign slot_free = !out_valid_q || dump.out_ready;
  assign at_last   = (idx_q == last_q);

  // Sequencer and output slot: capture a beat whenever the slot frees up, hold it under backpressure.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      last_q      <= '0;
      out_valid_q <= 1'b0;
      out_index_q <= '0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (dump.start) begin
            idx_q   <= dump.first_reg;
            last_q  <= dump.last_reg;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (slot_free) begin
            out_valid_q <= 1'b1;
            out_index_q <= idx_q;
            out_data_q  <= dump.rf_data;
            out_last_q  <= at_last;
            if (at_last) begin
              state_q <= ST_DRAIN;
            end else begin
              idx_q <= idx_d;
            end
          end
        end
        ST_DRAIN: begin
          if (out_valid_q && dump.out_ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign dump.busy      = (state_q != ST_IDLE);
  assign dump.done      = done_q;
  assign dump.rf_addr   = (state_q == ST_RUN) ? idx_q : '0;
  assign dump.out_valid = out_valid_q;
  assign dump.out_index = out_index_q;
  assign dump.out_data  = out_data_q;
  assign dump.out_last  = out_last_q;

endmodule

// File: tb/tb_reg_dump_reader.sv
// tb/tb_reg_dump_reader.sv - randomized directed bench for reg_dump_reader against a queue-free index model
module tb_reg_dump_reader;

  logic        clk;
  logic        reset;
  logic [31:0] regs [32];
  int          vectors;
  int          miscompares;

  reg_dump_reader_if #(.ADDR_W(5), .DATA_W(32)) dump ();

  reg_dump_reader #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .dump  (dump)
  );

  // Behavioural register file: combinational read, x0 hardwired to zero.
  assign dump.rf_data = (dump.rf_addr == 5'd0) ? 32'd0 : regs[dump.rf_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},      32'(dump.busy),      32'd0);
    check({tag, "_done"},      32'(dump.done),      32'd0);
    check({tag, "_rf_addr"},   32'(dump.rf_addr),   32'd0);
    check({tag, "_out_valid"}, 32'(dump.out_valid), 32'd0);
    check({tag, "_out_index"}, 32'(dump.out_index), 32'd0);
    check({tag, "_out_data"},  dump.out_data,       32'd0);
    check({tag, "_out_last"},  32'(dump.out_last),  32'd0);
  endtask

  function automatic logic [31:0] model_value(input int idx);
    return (idx == 0) ? 32'd0 : regs[idx];
  endfunction

  // mode 0: ready always high, 1: fixed 1,0,0,1,0,1 pattern, 2: random.
  // abort_after > 0 resets the DUT once that many beats have been accepted.
  task automatic run_dump(input string tag, input int first, input int last, input int mode,
                          input int abort_after, input bit poke_start);
    int          n;
    int          k;
    int          cyc;
    int          exp_idx;
    bit          exp_done;
    bit          ready;
    bit          pat [6];
    logic        pv;
    logic        pr;
    logic [4:0]  pidx;
    logic [4:0]  prf;
    logic [31:0] pdata;
    logic        plast;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    n = ((last - first + 32) % 32) + 1;
    @(negedge clk);
    dump.start     = 1'b1;
    dump.first_reg = 5'(first);
    dump.last_reg  = 5'(last);
    @(negedge clk);
    dump.start     = 1'b0;
    dump.first_reg = 5'($urandom);
    dump.last_reg  = 5'($urandom);
    check({tag, "_busy_n1"},    32'(dump.busy),      32'd1);
    check({tag, "_rfaddr_n1"},  32'(dump.rf_addr),   32'(first));
    check({tag, "_valid_n1"},   32'(dump.out_valid), 32'd0);
    k = 0; exp_done = 1'b0; pv = 1'b0; pr = 1'b0;
    pidx = '0; prf = '0; pdata = '0; plast = 1'b0;
    for (cyc = 0; cyc < 3000; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (poke_start) begin
        dump.start = (cyc == 0);
        if (cyc == 0) begin
          dump.first_reg = 5'(first + 9);
          dump.last_reg  = 5'(first + 20);
        end
      end
      if (pv && !pr) begin
        check({tag, "_stall_valid"}, 32'(dump.out_valid), 32'd1);
        check({tag, "_stall_index"}, 32'(dump.out_index), 32'(pidx));
        check({tag, "_stall_data"},  dump.out_data,       pdata);
        check({tag, "_stall_last"},  32'(dump.out_last),  32'(plast));
        check({tag, "_stall_rf"},    32'(dump.rf_addr),   32'(prf));
      end
      check({tag, "_done"}, 32'(dump.done), 32'(exp_done));
      if (exp_done) begin
        check({tag, "_busy_end"}, 32'(dump.busy), 32'd0);
        break;
      end
      check({tag, "_busy"}, 32'(dump.busy), 32'd1);
      case (mode)
        0:       ready = 1'b1;
        1:       ready = pat[cyc % 6];
        default: ready = 1'($urandom_range(0, 1));
      endcase
      dump.out_ready = ready;
      if (dump.out_valid && ready) begin
        exp_idx = (first + k) % 32;
        check({tag, "_index"}, 32'(dump.out_index), 32'(exp_idx));
        check({tag, "_data"},  dump.out_data,       model_value(exp_idx));
        check({tag, "_last"},  32'(dump.out_last),  32'(k == n - 1));
        k++;
        if (k == n) exp_done = 1'b1;
        if (k > n) break;
      end
      if (abort_after > 0 && k == abort_after) begin
        #2 reset = 1'b1;
        #1 check_all_zero({tag, "_rst_async"});
        @(negedge clk);
        check_all_zero({tag, "_rst_hold"});
        dump.start = 1'b0;
        reset = 1'b0;
        #1 check_all_zero({tag, "_rst_rel"});
        @(negedge clk);
        check_all_zero({tag, "_rst_after"});
        return;
      end
      pv = dump.out_valid; pr = ready;
      pidx = dump.out_index; pdata = dump.out_data; plast = dump.out_last; prf = dump.rf_addr;
    end
    check({tag, "_beat_count"}, 32'(k), 32'(n));
    check({tag, "_completed"}, 32'(exp_done), 32'd1);
    dump.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check({tag, "_quiet_valid"}, 32'(dump.out_valid), 32'd0);
      check({tag, "_quiet_busy"},  32'(dump.busy),      32'd0);
      check({tag, "_quiet_done"},  32'(dump.done),      32'd0);
    end
  endtask

  initial begin
    int f;
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;

    // Reset with random inputs, then the first cycle after release.
    for (int i = 0; i < 3; i++) begin
      dump.start     = 1'($urandom);
      dump.first_reg = 5'($urandom);
      dump.last_reg  = 5'($urandom);
      dump.out_ready = 1'($urandom);
      @(negedge clk);
      check_all_zero("reset");
    end
    dump.start = 1'b0;
    reset = 1'b0;
    #1 check_all_zero("reset_rel");
    @(negedge clk);
    check_all_zero("reset_c1");

    // Preloaded file x_i = 0x1000 + i.
    for (int i = 0; i < 32; i++) regs[i] = 32'h1000 + 32'(i);
    run_dump("full",   0, 31, 0, 0, 1'b0);
    run_dump("bkpr",   0, 31, 1, 0, 1'b0);
    run_dump("wrap",  30,  1, 0, 0, 1'b0);
    run_dump("single", 7,  7, 0, 0, 1'b1);
    run_dump("ign",    4, 12, 2, 0, 1'b1);
    run_dump("abort",  0, 31, 0, 3, 1'b0);
    run_dump("after",  2,  3, 0, 0, 1'b0);

    // Randomized file contents and ranges, including the full-wrap case first=last+1.
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    run_dump("fullwrap", 5, 4, 2, 0, 1'b0);
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 32; i++) regs[i] = $urandom;
      f = int'($urandom_range(0, 31));
      run_dump("rand", f, int'($urandom_range(0, 31)), int'($urandom_range(0, 2)), 0, 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
